// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: access-size codes,
// FSM states and the alignment/legality check used on request acceptance.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    RMW_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Unsupported size codes are folded into the misaligned case.
  function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    if (is_store) begin
      case (f3)
        SB:      bad = 1'b0;
        SH:      bad = off[0];
        SW:      bad = |off;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        LB, LBU: bad = 1'b0;
        LH, LHU: bad = off[0];
        LW:      bad = |off;
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Byte-lane steering: merges store data into an old word and right-aligns
// the addressed lane of a read word for loads.
module mem_access_unit_lane_merge
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged_word,
  output logic [31:0] load_word
);

  logic [31:0] shifted;

  always_comb begin
    merged_word = old_word;
    case (size)
      SZ_BYTE: merged_word[{byte_off, 3'b000} +: 8]     = new_data[7:0];
      SZ_HALF: merged_word[{byte_off[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged_word = new_data;
    endcase
  end

  always_comb begin
    shifted = old_word >> {byte_off, 3'b000};
    case (size)
      SZ_BYTE: load_word = {24'b0, shifted[7:0]};
      SZ_HALF: load_word = {16'b0, shifted[15:0]};
      default: load_word = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder for a word-wide synchronous-read RAM without byte
// enables; sub-word stores go through a read-modify-write cycle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop_flag,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       ram_data_out,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_t      state, next_state;
  logic        req_any, req_store, bad;
  logic [31:0] merged_word, load_word;
  logic        unused_bits;

  // A simultaneous load and store request is handled as a store.
  assign req_store = mem_write;
  assign req_any   = (mem_read | mem_write) & ~stop_flag;
  assign bad       = access_bad(req_store, func3, addr[1:0]);
  assign ram_addr  = addr[ADDR_W+1:2];

  assign unused_bits = ^{addr[31:ADDR_W+2], RD_LAT == 1};

  mem_access_unit_lane_merge u_lane_merge (
    .old_word    (ram_dout),
    .new_data    (wdata),
    .size        (func3[1:0]),
    .byte_off    (addr[1:0]),
    .merged_word (merged_word),
    .load_word   (load_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (bad)                  next_state = DONE;
          else if (!req_store)      next_state = LD_WAIT;
          else if (func3 == SW)     next_state = DONE;
          else                      next_state = RMW_WAIT;
        end
      end
      LD_WAIT:  next_state = DONE;
      RMW_WAIT: next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are forced inactive while reset is held, even with a request present.
  always_comb begin
    stall        = 1'b0;
    ram_we       = 1'b0;
    ram_din      = 32'b0;
    misalign_err = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (req_any) begin
            stall = 1'b1;
            if (bad) begin
              misalign_err = 1'b1;
            end else if (req_store && func3 == SW) begin
              ram_we  = 1'b1;
              ram_din = wdata;
            end
          end
        end
        LD_WAIT:  stall = 1'b1;
        RMW_WAIT: begin
          stall   = 1'b1;
          ram_we  = 1'b1;
          ram_din = merged_word;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ram_data_out <= 32'b0;
    else if (state == IDLE && req_any && bad)
      ram_data_out <= 32'b0;
    else if (state == LD_WAIT)
      ram_data_out <= load_word;
  end

endmodule
